fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter FFT1_LAT, default 3: cycles the first 8-point FFT stage needs (legal range 1..15).
REQ-002 SHALL have parameter TW_LAT, default 2: cycles the inter-dimension twiddle multiply needs (1..15).
REQ-003 SHALL have parameter CB_LAT, default 8: cycles the corner-bender (transpose) needs (1..15).
REQ-004 SHALL have parameter FFT2_LAT, default 3: cycles the second 8-point FFT stage needs (1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_start, input, 1 bit: frame-start pulse; sample 0 arrives the following cycle.
REQ-008 SHALL have port mode, input, 1 bit: 0 = forward FFT, 1 = inverse; sampled only when a frame is accepted.
REQ-009 SHALL have port in_we, output, 1 bit: input-buffer write enable.
REQ-010 SHALL have ports in_seg and in_pos, output, 3 bits each: target segment and slot of the current input sample.
REQ-011 SHALL have ports fft1_en, tw_en, cb_en and fft2_en, output, 1 bit each: stage enables.
REQ-012 SHALL have port mode_q, output, 1 bit: latched mode for the current frame.
REQ-013 SHALL have ports out_seg and out_pos, output, 3 bits each: output-buffer read select.
REQ-014 SHALL have port data_out, output, 1 bit: the output sample is valid.
REQ-015 SHALL have ports busy, frame_done and overrun, output, 1 bit each.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, LOAD, FFT1, TWID, CB, FFT2 and UNLOAD; every output SHALL be registered or decoded from state and counter only.
REQ-017 SHALL, in IDLE with data_start=1, move to LOAD at the next edge, clear the 6-bit counter cnt and latch mode into mode_q.
REQ-018 SHALL stay in LOAD for exactly 64 cycles with in_we=1, in_seg=cnt[5:3] and in_pos=cnt[2:0].
REQ-019 SHALL, on cnt=63 in LOAD, move to FFT1 and clear cnt.
REQ-020 SHALL hold FFT1, TWID, CB and FFT2 for exactly FFT1_LAT, TW_LAT, CB_LAT and FFT2_LAT cycles respectively, asserting only that state's enable, then advance in that order.
REQ-021 SHALL, in UNLOAD, run 64 cycles with data_out=1, out_seg=cnt[2:0] and out_pos=cnt[5:3], so samples leave in natural order k = out_seg + 8*out_pos.
REQ-022 SHALL pulse frame_done for one cycle on the UNLOAD cycle with cnt=63 and SHALL return to IDLE at the next edge.
REQ-023 SHALL give data_start at cycle T the following timing: LOAD at T+1..T+64; first data_out at T+65+FFT1_LAT+TW_LAT+CB_LAT+FFT2_LAT (T+81 with defaults); last data_out at T+144 with defaults.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL hold mode_q constant from acceptance until the frame ends, regardless of mode toggling.
REQ-026 SHALL ignore data_start while busy, including on the frame_done cycle, and SHALL set sticky overrun=1; only rst clears overrun.
REQ-027 SHALL accept data_start asserted in the first IDLE cycle after UNLOAD, with no dead cycle required.
REQ-028 SHALL use a single 6-bit cnt that wraps 63->0 only on state transitions; stage timers SHALL reuse cnt[3:0].
REQ-029 SHALL keep all enable, in_*, out_* and data_out outputs at 0 outside their owning state.

Reset
REQ-030 SHALL, when rst=1 at an edge, force IDLE, cnt=0, mode_q=0, overrun=0 and every output 0 at the next edge, in any state.
REQ-031 SHALL give rst priority over a simultaneous data_start; the pulse SHALL be lost.
REQ-032 SHALL discard a frame interrupted by rst mid-operation without any frame_done.

Structure
REQ-033 SHALL place the state-encoding typedef, the default latency constants and the FRAME_LEN=64 constant in the shared package fft_ctrl_pkg.
REQ-034 SHALL include the 6-bit counter with load/clear/terminal-count compare as the single sub-module fft_seq_counter; everything else SHALL be flat.

Verification
REQ-035 SHALL cover a nominal frame: data_start at cycle 10, defaults -> in_we at cycles 11..74, first data_out at 91, frame_done at 154, busy=0 at 155.
REQ-036 SHALL cover mode latching: mode=1 at acceptance, mode=0 from cycle 12 -> mode_q=1 until IDLE.
REQ-037 SHALL cover an overrun: data_start during FFT2 -> ignored, overrun=1 and stays 1, frame timing unchanged.
REQ-038 SHALL cover back-to-back frames: data_start on the first IDLE cycle after frame_done -> new LOAD starts the next cycle, overrun=0.
REQ-039 SHALL cover reset mid-operation: rst during LOAD cnt=30 -> IDLE with all outputs 0 next cycle and no frame_done.
REQ-040 SHALL cover order and parameters: with FFT1_LAT=1 and CB_LAT=15, in_seg/in_pos sweep 0..7 nested, (out_seg, out_pos) yields k=0..63 in order, and first data_out lands at T+65+1+2+15+3.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Holds the state encoding, frame length and default stage latencies.
package fft_ctrl_pkg;

    localparam int unsigned FRAME_LEN    = 64;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned FFT1_LAT_DEF = 3;
    localparam int unsigned TW_LAT_DEF   = 2;
    localparam int unsigned CB_LAT_DEF   = 8;
    localparam int unsigned FFT2_LAT_DEF = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFft1,
        StTwid,
        StCb,
        StFft2,
        StUnload
    } seq_state_e;

    // Terminal count for a phase lasting `len` cycles with cnt starting at 0.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/fft_seq_counter.sv
// Shared 6-bit phase counter: synchronous clear, increment and terminal-count compare.
// Stage timers use the same counter; their terminal values never exceed 15.
module fft_seq_counter
    import fft_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Control sequencer for a 64-point (8x8) FFT frame: load, two FFT stages with
// twiddle and transpose in between, then natural-order unload.
module fft_frame_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned FFT1_LAT = FFT1_LAT_DEF,
    parameter int unsigned TW_LAT   = TW_LAT_DEF,
    parameter int unsigned CB_LAT   = CB_LAT_DEF,
    parameter int unsigned FFT2_LAT = FFT2_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_start,
    input  logic       mode,
    output logic       in_we,
    output logic [2:0] in_seg,
    output logic [2:0] in_pos,
    output logic       fft1_en,
    output logic       tw_en,
    output logic       cb_en,
    output logic       fft2_en,
    output logic       mode_q,
    output logic [2:0] out_seg,
    output logic [2:0] out_pos,
    output logic       data_out,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    seq_state_e       state_d, state_q;
    logic             mode_d;
    logic             overrun_d, overrun_q;
    logic             cnt_clr, cnt_tc;
    logic [CNT_W-1:0] cnt, tc_val;

    fft_seq_counter u_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (cnt_clr),
        .inc_i    (1'b1),
        .tc_val_i (tc_val),
        .cnt_o    (cnt),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        overrun_d = overrun_q | (data_start && (state_q != StIdle));
        cnt_clr   = 1'b0;
        tc_val    = last_cnt(FRAME_LEN);
        case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                if (data_start) begin
                    state_d = StLoad;
                    mode_d  = mode;
                end
            end
            StLoad: begin
                if (cnt_tc) begin
                    state_d = StFft1;
                    cnt_clr = 1'b1;
                end
            end
            StFft1: begin
                tc_val = last_cnt(FFT1_LAT);
                if (cnt_tc) begin
                    state_d = StTwid;
                    cnt_clr = 1'b1;
                end
            end
            StTwid: begin
                tc_val = last_cnt(TW_LAT);
                if (cnt_tc) begin
                    state_d = StCb;
                    cnt_clr = 1'b1;
                end
            end
            StCb: begin
                tc_val = last_cnt(CB_LAT);
                if (cnt_tc) begin
                    state_d = StFft2;
                    cnt_clr = 1'b1;
                end
            end
            StFft2: begin
                tc_val = last_cnt(FFT2_LAT);
                if (cnt_tc) begin
                    state_d = StUnload;
                    cnt_clr = 1'b1;
                end
            end
            StUnload: begin
                if (cnt_tc) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            overrun_q <= overrun_d;
        end
    end

    // Moore outputs: pure decode of the registered state and counter.
    always_comb begin
        in_we      = (state_q == StLoad);
        in_seg     = in_we ? cnt[5:3] : 3'd0;
        in_pos     = in_we ? cnt[2:0] : 3'd0;
        fft1_en    = (state_q == StFft1);
        tw_en      = (state_q == StTwid);
        cb_en      = (state_q == StCb);
        fft2_en    = (state_q == StFft2);
        data_out   = (state_q == StUnload);
        out_seg    = data_out ? cnt[2:0] : 3'd0;
        out_pos    = data_out ? cnt[5:3] : 3'd0;
        frame_done = data_out && cnt_tc;
        busy       = (state_q != StIdle);
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: a timeline model of each frame checked every cycle,
// plus literal spot checks. Two instances: default latencies and (1,2,15,3).
module tb_fft_frame_sequencer;

    typedef struct packed {
        logic       in_we;
        logic [2:0] in_seg;
        logic [2:0] in_pos;
        logic       fft1_en;
        logic       tw_en;
        logic       cb_en;
        logic       fft2_en;
        logic       mode_q;
        logic [2:0] out_seg;
        logic [2:0] out_pos;
        logic       data_out;
        logic       busy;
        logic       frame_done;
        logic       overrun;
    } outs_t;

    localparam int LAT0 [4] = '{3, 2, 8, 3};
    localparam int LAT1 [4] = '{1, 2, 15, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs [2];
    logic ds [2];
    logic md [2];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    logic       a_in_we, a_fft1, a_tw, a_cb, a_fft2, a_mq, a_dout, a_busy, a_fd, a_ovr;
    logic [2:0] a_iseg, a_ipos, a_oseg, a_opos;
    logic       b_in_we, b_fft1, b_tw, b_cb, b_fft2, b_mq, b_dout, b_busy, b_fd, b_ovr;
    logic [2:0] b_iseg, b_ipos, b_oseg, b_opos;
    outs_t      obs [2];

    fft_frame_sequencer dut_a (
        .clk(clk), .rst(rs[0]), .data_start(ds[0]), .mode(md[0]),
        .in_we(a_in_we), .in_seg(a_iseg), .in_pos(a_ipos),
        .fft1_en(a_fft1), .tw_en(a_tw), .cb_en(a_cb), .fft2_en(a_fft2),
        .mode_q(a_mq), .out_seg(a_oseg), .out_pos(a_opos), .data_out(a_dout),
        .busy(a_busy), .frame_done(a_fd), .overrun(a_ovr)
    );

    fft_frame_sequencer #(.FFT1_LAT(1), .TW_LAT(2), .CB_LAT(15), .FFT2_LAT(3)) dut_b (
        .clk(clk), .rst(rs[1]), .data_start(ds[1]), .mode(md[1]),
        .in_we(b_in_we), .in_seg(b_iseg), .in_pos(b_ipos),
        .fft1_en(b_fft1), .tw_en(b_tw), .cb_en(b_cb), .fft2_en(b_fft2),
        .mode_q(b_mq), .out_seg(b_oseg), .out_pos(b_opos), .data_out(b_dout),
        .busy(b_busy), .frame_done(b_fd), .overrun(b_ovr)
    );

    assign obs[0] = {a_in_we, a_iseg, a_ipos, a_fft1, a_tw, a_cb, a_fft2, a_mq,
                     a_oseg, a_opos, a_dout, a_busy, a_fd, a_ovr};
    assign obs[1] = {b_in_we, b_iseg, b_ipos, b_fft1, b_tw, b_cb, b_fft2, b_mq,
                     b_oseg, b_opos, b_dout, b_busy, b_fd, b_ovr};

    // Model state: frame start cycle per instance, sticky overrun, latched mode.
    bit m_act [2];
    int m_start [2];
    bit m_ovr [2];
    bit m_mode [2];

    function automatic int lat(input int i, input int s);
        return (i == 0) ? LAT0[s] : LAT1[s];
    endfunction

    function automatic int mid_len(input int i);
        return lat(i, 0) + lat(i, 1) + lat(i, 2) + lat(i, 3);
    endfunction

    function automatic bit busy_m(input int i, input int c);
        int d;
        d = c - m_start[i];
        return m_act[i] && (d >= 1) && (d <= 128 + mid_len(i));
    endfunction

    function automatic outs_t model_out(input int i, input int c);
        outs_t o;
        int    d, u, e1, e2, e3, e4;
        o = '0;
        o.overrun = m_ovr[i];
        o.mode_q  = m_mode[i];
        if (busy_m(i, c)) begin
            d  = c - m_start[i];
            e1 = 64 + lat(i, 0);
            e2 = e1 + lat(i, 1);
            e3 = e2 + lat(i, 2);
            e4 = e3 + lat(i, 3);
            o.busy = 1'b1;
            if (d <= 64) begin
                o.in_we  = 1'b1;
                o.in_seg = 3'((d - 1) / 8);
                o.in_pos = 3'((d - 1) % 8);
            end else if (d <= e1) begin
                o.fft1_en = 1'b1;
            end else if (d <= e2) begin
                o.tw_en = 1'b1;
            end else if (d <= e3) begin
                o.cb_en = 1'b1;
            end else if (d <= e4) begin
                o.fft2_en = 1'b1;
            end else begin
                u = d - e4 - 1;
                o.data_out   = 1'b1;
                o.out_seg    = 3'(u % 8);
                o.out_pos    = 3'(u / 8);
                o.frame_done = (u == 63);
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin
                m_act[i]  <= 1'b0;
                m_ovr[i]  <= 1'b0;
                m_mode[i] <= 1'b0;
            end else if (ds[i]) begin
                if (busy_m(i, cyc)) begin
                    m_ovr[i] <= 1'b1;
                end else begin
                    m_act[i]   <= 1'b1;
                    m_start[i] <= cyc;
                    m_mode[i]  <= md[i];
                end
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1 && !done) begin
            for (int i = 0; i < 2; i++) begin
                outs_t exp_o;
                exp_o = model_out(i, cyc);
                n_chk = n_chk + 1;
                if (obs[i] !== exp_o) begin
                    n_fail = n_fail + 1;
                    $display("FAIL cycle_cmp dut%0d cyc=%0d got=%h want=%h",
                             i, cyc, obs[i], exp_o);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #40000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rs[i] = 1'b1; ds[i] = 1'b0; md[i] = 1'b0;
            m_act[i] = 1'b0; m_start[i] = 0; m_ovr[i] = 1'b0; m_mode[i] = 1'b0;
        end
        wait_cyc(3);  rs[0] = 1'b0; rs[1] = 1'b0;
        wait_cyc(5);  chk("reset_busy", int'(a_busy), 0); chk("reset_ovr", int'(a_ovr), 0);
        // Nominal frame on both instances; dut_a also exercises mode latching.
        wait_cyc(10); ds[0] = 1'b1; md[0] = 1'b1; ds[1] = 1'b1; md[1] = 1'b0;
        wait_cyc(11); ds[0] = 1'b0; ds[1] = 1'b0;
        chk("a_in_we@11", int'(a_in_we), 1); chk("a_in_seg@11", int'(a_iseg), 0);
        chk("b_in_we@11", int'(b_in_we), 1);
        wait_cyc(12); md[0] = 1'b0;
        wait_cyc(19); chk("b_in_seg@19", int'(b_iseg), 1); chk("b_in_pos@19", int'(b_ipos), 0);
        wait_cyc(74); chk("a_in_we@74", int'(a_in_we), 1); chk("a_in_pos@74", int'(a_ipos), 7);
        wait_cyc(75); chk("a_in_we@75", int'(a_in_we), 0); chk("a_fft1@75", int'(a_fft1), 1);
        wait_cyc(90); chk("a_dout@90", int'(a_dout), 0);
        wait_cyc(91); chk("a_dout@91", int'(a_dout), 1);
        wait_cyc(95); chk("b_dout@95", int'(b_dout), 0); chk("b_cb@95", int'(b_cb), 0);
        wait_cyc(96); chk("b_dout@96", int'(b_dout), 1); chk("b_oseg@96", int'(b_oseg), 0);
        wait_cyc(97); chk("b_oseg@97", int'(b_oseg), 1);
        wait_cyc(100); chk("a_mode_q@100", int'(a_mq), 1);
        wait_cyc(104); chk("b_opos@104", int'(b_opos), 1); chk("b_oseg@104", int'(b_oseg), 0);
        wait_cyc(154); chk("a_done@154", int'(a_fd), 1); chk("a_mode_q@154", int'(a_mq), 1);
        // Back-to-back frame on the first idle cycle.
        wait_cyc(155); chk("a_busy@155", int'(a_busy), 0); ds[0] = 1'b1; md[0] = 1'b0;
        wait_cyc(156); ds[0] = 1'b0;
        chk("a_in_we@156", int'(a_in_we), 1); chk("a_ovr@156", int'(a_ovr), 0);
        chk("a_mode_q@156", int'(a_mq), 0);
        wait_cyc(159); chk("b_done@159", int'(b_fd), 1);
        wait_cyc(160); chk("b_busy@160", int'(b_busy), 0);
        wait_cyc(299); chk("a_done@299", int'(a_fd), 1);
        // Overrun: start pulse during FFT2 is ignored but recorded.
        wait_cyc(310); ds[0] = 1'b1;
        wait_cyc(311); ds[0] = 1'b0;
        wait_cyc(389); chk("a_fft2@389", int'(a_fft2), 1); ds[0] = 1'b1;
        wait_cyc(390); ds[0] = 1'b0; chk("a_ovr@390", int'(a_ovr), 1);
        wait_cyc(454); chk("a_done@454", int'(a_fd), 1);
        wait_cyc(455); chk("a_ovr@455", int'(a_ovr), 1); chk("a_busy@455", int'(a_busy), 0);
        wait_cyc(460); rs[0] = 1'b1;
        wait_cyc(461); rs[0] = 1'b0; chk("a_ovr@461", int'(a_ovr), 0);
        // Reset in the middle of LOAD (cnt=30).
        wait_cyc(470); ds[0] = 1'b1;
        wait_cyc(471); ds[0] = 1'b0;
        wait_cyc(501);
        chk("a_in_seg@501", int'(a_iseg), 3); chk("a_in_pos@501", int'(a_ipos), 6);
        rs[0] = 1'b1;
        wait_cyc(502); rs[0] = 1'b0;
        chk("a_busy@502", int'(a_busy), 0); chk("a_in_we@502", int'(a_in_we), 0);
        // Reset wins over a simultaneous start pulse.
        wait_cyc(520); rs[0] = 1'b1; ds[0] = 1'b1;
        wait_cyc(521); rs[0] = 1'b0; ds[0] = 1'b0; chk("a_busy@521", int'(a_busy), 0);
        wait_cyc(640); chk("a_done@640", int'(a_fd), 0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
